// File: rtl/rps_pkg.sv
// Shared constants for the stone/paper/scissors match sequencer:
// move codes, round result codes, FSM state codes and a result-to-ASCII helper.
`timescale 1ns/1ps
package rps_pkg;

  // Player move encoding
  localparam logic [1:0] MOVE_STONE    = 2'b00;
  localparam logic [1:0] MOVE_PAPER    = 2'b01;
  localparam logic [1:0] MOVE_SCISSORS = 2'b10;
  localparam logic [1:0] MOVE_INVALID  = 2'b11;

  // Round result encoding (RES_P1/RES_P2 double as match_winner codes)
  localparam logic [1:0] RES_TIE  = 2'b00;
  localparam logic [1:0] RES_P1   = 2'b01;
  localparam logic [1:0] RES_P2   = 2'b10;
  localparam logic [1:0] RES_VOID = 2'b11;

  // FSM state encoding, visible on state_o
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_COLLECT = 3'd1;
  localparam logic [2:0] ST_JUDGE   = 3'd2;
  localparam logic [2:0] ST_REPORT  = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  // Printable character for a round result: '0', '1', '2' or '?'
  function automatic logic [7:0] res_to_ascii(input logic [1:0] res);
    logic [7:0] ch;
    case (res)
      RES_TIE: ch = 8'h30;
      RES_P1:  ch = 8'h31;
      RES_P2:  ch = 8'h32;
      default: ch = 8'h3F;
    endcase
    return ch;
  endfunction

endpackage

// File: rtl/rps_match_ctrl_if.sv
// Player-side move handshake bundle: one valid/move/ready triple per player.
// master = player/pin side, slave = match controller.
`timescale 1ns/1ps
interface rps_match_ctrl_if;
  logic       p1_valid;
  logic [1:0] p1_move;
  logic       p1_ready;
  logic       p2_valid;
  logic [1:0] p2_move;
  logic       p2_ready;

  modport master (
    output p1_valid, p1_move, p2_valid, p2_move,
    input  p1_ready, p2_ready
  );

  modport slave (
    input  p1_valid, p1_move, p2_valid, p2_move,
    output p1_ready, p2_ready
  );
endinterface

// File: rtl/rps_judge.sv
// Combinational round judge: compares two moves and returns tie / P1 / P2 / void.
`timescale 1ns/1ps
module rps_judge
  import rps_pkg::*;
(
  input  logic [1:0] p1_move,
  input  logic [1:0] p2_move,
  output logic [1:0] result
);

  // Any invalid move voids the round; otherwise stone>scissors, paper>stone, scissors>paper
  always_comb begin
    result = RES_VOID;
    if ((p1_move == MOVE_INVALID) || (p2_move == MOVE_INVALID)) begin
      result = RES_VOID;
    end else if (p1_move == p2_move) begin
      result = RES_TIE;
    end else begin
      case ({p1_move, p2_move})
        {MOVE_STONE, MOVE_SCISSORS},
        {MOVE_PAPER, MOVE_STONE},
        {MOVE_SCISSORS, MOVE_PAPER}: result = RES_P1;
        default:                     result = RES_P2;
      endcase
    end
  end

endmodule

// File: rtl/rps_match_ctrl.sv
// Match sequencer: collects one move per player per round, enforces a round
// timeout, judges the round, keeps scores and declares the match winner.
// Optional build macro RPS_ASCII_OUT_EN adds ascii_out, a printable copy of
// round_result updated on the same edge.
`timescale 1ns/1ps
module rps_match_ctrl
  import rps_pkg::*;
#(
  parameter int unsigned WINS_TO_MATCH  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  rps_match_ctrl_if.slave  bus,
  output logic             round_done,
  output logic [1:0]       round_result,
  output logic [3:0]       p1_score,
  output logic [3:0]       p2_score,
  output logic             match_done,
  output logic [1:0]       match_winner,
  output logic [2:0]       state_o
`ifdef RPS_ASCII_OUT_EN
  ,
  output logic [7:0]       ascii_out
`endif
);

  localparam logic [3:0]  WINS_L    = 4'(WINS_TO_MATCH);
  localparam logic [16:0] TIMEOUT_L = 17'(TIMEOUT_CYCLES);

  logic [2:0]  state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic        p1_cap_q, p1_cap_d;
  logic        p2_cap_q, p2_cap_d;
  logic [1:0]  p1_move_q, p1_move_d;
  logic [1:0]  p2_move_q, p2_move_d;
  logic        forced_q, forced_d;
  logic [1:0]  forced_res_q, forced_res_d;
  logic [1:0]  round_result_q, round_result_d;
  logic [3:0]  p1_score_q, p1_score_d;
  logic [3:0]  p2_score_q, p2_score_d;
  logic [1:0]  match_winner_q, match_winner_d;

  logic        p1_ready_s, p2_ready_s;
  logic        p1_take_s, p2_take_s;
  logic        p1_cap_now_s, p2_cap_now_s;
  logic [16:0] timer_inc_s;
  logic        timeout_s;
  logic [1:0]  judge_res_s;
  logic [1:0]  round_res_s;

  rps_judge u_judge (
    .p1_move (p1_move_q),
    .p2_move (p2_move_q),
    .result  (judge_res_s)
  );

  // Handshake readiness, capture strobes and timeout detection for this cycle
  always_comb begin
    p1_ready_s   = ena & (state_q == ST_COLLECT) & ~p1_cap_q;
    p2_ready_s   = ena & (state_q == ST_COLLECT) & ~p2_cap_q;
    p1_take_s    = bus.p1_valid & p1_ready_s;
    p2_take_s    = bus.p2_valid & p2_ready_s;
    p1_cap_now_s = p1_cap_q | p1_take_s;
    p2_cap_now_s = p2_cap_q | p2_take_s;
    timer_inc_s  = {1'b0, timer_q} + 17'd1;
    timeout_s    = (timer_inc_s == TIMEOUT_L);
  end

  // Round outcome: a timeout-forced result overrides the judge
  always_comb begin
    round_res_s = judge_res_s;
    if (forced_q) begin
      round_res_s = forced_res_q;
    end else begin
      round_res_s = judge_res_s;
    end
  end

  // Next-state and datapath update; everything holds while ena is low
  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    p1_cap_d       = p1_cap_q;
    p2_cap_d       = p2_cap_q;
    p1_move_d      = p1_move_q;
    p2_move_d      = p2_move_q;
    forced_d       = forced_q;
    forced_res_d   = forced_res_q;
    round_result_d = round_result_q;
    p1_score_d     = p1_score_q;
    p2_score_d     = p2_score_q;
    match_winner_d = match_winner_q;
    if (ena) begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            p1_score_d     = 4'd0;
            p2_score_d     = 4'd0;
            match_winner_d = RES_TIE;
            timer_d        = 16'd0;
            p1_cap_d       = 1'b0;
            p2_cap_d       = 1'b0;
            forced_d       = 1'b0;
            state_d        = ST_COLLECT;
          end else begin
            state_d = state_q;
          end
        end
        ST_COLLECT: begin
          timer_d = timer_inc_s[15:0];
          if (p1_take_s) begin
            p1_cap_d  = 1'b1;
            p1_move_d = bus.p1_move;
          end else begin
            p1_cap_d  = p1_cap_q;
          end
          if (p2_take_s) begin
            p2_cap_d  = 1'b1;
            p2_move_d = bus.p2_move;
          end else begin
            p2_cap_d  = p2_cap_q;
          end
          if (p1_cap_now_s && p2_cap_now_s) begin
            forced_d = 1'b0;
            state_d  = ST_JUDGE;
          end else if (timeout_s) begin
            forced_d = 1'b1;
            state_d  = ST_JUDGE;
            if (p1_cap_now_s) begin
              forced_res_d = RES_P1;
            end else if (p2_cap_now_s) begin
              forced_res_d = RES_P2;
            end else begin
              forced_res_d = RES_VOID;
            end
          end else begin
            state_d = ST_COLLECT;
          end
        end
        ST_JUDGE: begin
          round_result_d = round_res_s;
          case (round_res_s)
            RES_P1:  p1_score_d = p1_score_q + 4'd1;
            RES_P2:  p2_score_d = p2_score_q + 4'd1;
            default: p1_score_d = p1_score_q;
          endcase
          state_d = ST_REPORT;
        end
        ST_REPORT: begin
          if (p1_score_q == WINS_L) begin
            match_winner_d = RES_P1;
            state_d        = ST_DONE;
          end else if (p2_score_q == WINS_L) begin
            match_winner_d = RES_P2;
            state_d        = ST_DONE;
          end else begin
            timer_d  = 16'd0;
            p1_cap_d = 1'b0;
            p2_cap_d = 1'b0;
            forced_d = 1'b0;
            state_d  = ST_COLLECT;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      timer_q        <= 16'd0;
      p1_cap_q       <= 1'b0;
      p2_cap_q       <= 1'b0;
      p1_move_q      <= 2'b00;
      p2_move_q      <= 2'b00;
      forced_q       <= 1'b0;
      forced_res_q   <= 2'b00;
      round_result_q <= 2'b00;
      p1_score_q     <= 4'd0;
      p2_score_q     <= 4'd0;
      match_winner_q <= 2'b00;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      p1_cap_q       <= p1_cap_d;
      p2_cap_q       <= p2_cap_d;
      p1_move_q      <= p1_move_d;
      p2_move_q      <= p2_move_d;
      forced_q       <= forced_d;
      forced_res_q   <= forced_res_d;
      round_result_q <= round_result_d;
      p1_score_q     <= p1_score_d;
      p2_score_q     <= p2_score_d;
      match_winner_q <= match_winner_d;
    end
  end

`ifdef RPS_ASCII_OUT_EN
  logic [7:0] ascii_q, ascii_d;

  // Printable copy of the round result, loaded on the same edge as round_result
  always_comb begin
    ascii_d = ascii_q;
    if (ena && (state_q == ST_JUDGE)) begin
      ascii_d = res_to_ascii(round_res_s);
    end else begin
      ascii_d = ascii_q;
    end
  end

  // ASCII result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ascii_q <= 8'h00;
    end else begin
      ascii_q <= ascii_d;
    end
  end

  assign ascii_out = ascii_q;
`endif

  assign bus.p1_ready  = p1_ready_s;
  assign bus.p2_ready  = p2_ready_s;
  assign round_done    = (state_q == ST_REPORT);
  assign round_result  = round_result_q;
  assign p1_score      = p1_score_q;
  assign p2_score      = p2_score_q;
  assign match_done    = (state_q == ST_DONE);
  assign match_winner  = match_winner_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_rps_match_ctrl.sv
// Self-checking bench for rps_match_ctrl: directed rounds from the test plan
// followed by randomized rounds, checked against a round-level reference model.
`timescale 1ns/1ps
module tb_rps_match_ctrl;

  localparam int TB_WINS = 2;
  localparam int TB_TO   = 8;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       start;
  logic       round_done;
  logic [1:0] round_result;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic       match_done;
  logic [1:0] match_winner;
  logic [2:0] state_o;
`ifdef RPS_ASCII_OUT_EN
  logic [7:0] ascii_out;
`endif

  int n_vec;
  int n_err;

  // reference model: match scores and match status
  int m_s1;
  int m_s2;
  bit m_over;

  rps_match_ctrl_if bus ();

  rps_match_ctrl #(
    .WINS_TO_MATCH  (TB_WINS),
    .TIMEOUT_CYCLES (TB_TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .start        (start),
    .bus          (bus),
    .round_done   (round_done),
    .round_result (round_result),
    .p1_score     (p1_score),
    .p2_score     (p2_score),
    .match_done   (match_done),
    .match_winner (match_winner),
    .state_o      (state_o)
`ifdef RPS_ASCII_OUT_EN
    ,
    .ascii_out    (ascii_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Game rule in modular form: P1 wins when (m1 - m2) mod 3 == 1
  function automatic logic [1:0] ref_judge(input logic [1:0] a, input logic [1:0] b);
    if (a == 2'd3 || b == 2'd3) return 2'd3;
    if (a == b) return 2'd0;
    if (((int'(a) - int'(b) + 3) % 3) == 1) return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic [7:0] ref_ascii(input logic [1:0] r);
    if (r == 2'd3) return 8'h3F;
    return 8'h30 + 8'(r);
  endfunction

  // Called at a negedge with the DUT in IDLE or DONE
  task automatic start_match();
    ena   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    m_s1 = 0;
    m_s2 = 0;
    m_over = 1'b0;
    chk("start_state", 16'(state_o), 16'd1);
    chk("start_p1s", 16'(p1_score), 16'd0);
    chk("start_p2s", 16'(p2_score), 16'd0);
    chk("start_winner", 16'(match_winner), 16'd0);
    chk("start_mdone", 16'(match_done), 16'd0);
  endtask

  // One round: player N starts offering its move once tN enabled COLLECT
  // cycles have elapsed (tN < 0: never offers).
  task automatic play_round(input logic [1:0] m1, input logic [1:0] m2,
                            input int t1, input int t2,
                            input bit rnd, input bit hold5);
    int k;
    int it;
    bit c1;
    bit c2;
    bit fin;
    logic [1:0] exp_res;
    k = 0; it = 0; c1 = 1'b0; c2 = 1'b0; fin = 1'b0;
    while (!fin && it < 200) begin
      chk("collect_state", 16'(state_o), 16'd1);
      if (hold5 && it < 5) ena = 1'b0;
      else if (rnd) ena = ($urandom_range(0, 4) != 0);
      else ena = 1'b1;
      start = rnd ? ($urandom_range(0, 7) == 0) : 1'b0;
      bus.p1_valid = (t1 >= 0 && k >= t1);
      bus.p1_move  = m1;
      bus.p2_valid = (t2 >= 0 && k >= t2);
      bus.p2_move  = m2;
      #1;
      chk("p1_ready", 16'(bus.p1_ready), 16'(ena && !c1));
      chk("p2_ready", 16'(bus.p2_ready), 16'(ena && !c2));
      @(posedge clk);
      if (ena) begin
        if (bus.p1_valid) c1 = 1'b1;
        if (bus.p2_valid) c2 = 1'b1;
        k++;
        if ((c1 && c2) || k == TB_TO) fin = 1'b1;
      end
      @(negedge clk);
      it++;
    end
    chk("collect_bound", 16'(fin), 16'd1);
    if (c1 && c2) exp_res = ref_judge(m1, m2);
    else if (c1) exp_res = 2'd1;
    else if (c2) exp_res = 2'd2;
    else exp_res = 2'd3;
    ena = 1'b1;
    start = 1'b0;
    bus.p1_valid = 1'b0;
    bus.p2_valid = 1'b0;
    #1;
    chk("judge_state", 16'(state_o), 16'd2);
    chk("judge_rdone", 16'(round_done), 16'd0);
    chk("judge_p1rdy", 16'(bus.p1_ready), 16'd0);
    @(posedge clk);
    @(negedge clk);
    if (exp_res == 2'd1) m_s1++;
    if (exp_res == 2'd2) m_s2++;
    chk("report_rdone", 16'(round_done), 16'd1);
    chk("report_state", 16'(state_o), 16'd3);
    chk("round_result", 16'(round_result), 16'(exp_res));
    chk("p1_score", 16'(p1_score), 16'(m_s1));
    chk("p2_score", 16'(p2_score), 16'(m_s2));
`ifdef RPS_ASCII_OUT_EN
    chk("ascii_out", 16'(ascii_out), 16'(ref_ascii(exp_res)));
`endif
    @(posedge clk);
    @(negedge clk);
    chk("post_rdone", 16'(round_done), 16'd0);
    if (m_s1 == TB_WINS || m_s2 == TB_WINS) begin
      m_over = 1'b1;
      chk("done_state", 16'(state_o), 16'd4);
      chk("done_mdone", 16'(match_done), 16'd1);
      chk("done_winner", 16'(match_winner), (m_s1 == TB_WINS) ? 16'd1 : 16'd2);
    end else begin
      chk("next_state", 16'(state_o), 16'd1);
      chk("next_mdone", 16'(match_done), 16'd0);
      chk("next_winner", 16'(match_winner), 16'd0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, 16'(state_o), 16'd0);
    chk({tag, "_rdone"}, 16'(round_done), 16'd0);
    chk({tag, "_result"}, 16'(round_result), 16'd0);
    chk({tag, "_p1s"}, 16'(p1_score), 16'd0);
    chk({tag, "_p2s"}, 16'(p2_score), 16'd0);
    chk({tag, "_mdone"}, 16'(match_done), 16'd0);
    chk({tag, "_winner"}, 16'(match_winner), 16'd0);
    chk({tag, "_p1rdy"}, 16'(bus.p1_ready), 16'd0);
    chk({tag, "_p2rdy"}, 16'(bus.p2_ready), 16'd0);
`ifdef RPS_ASCII_OUT_EN
    chk({tag, "_ascii"}, 16'(ascii_out), 16'd0);
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    m_s1 = 0;
    m_s2 = 0;
    m_over = 1'b0;
    clk = 1'b0;
    rst_n = 1'b0;
    ena = 1'b1;
    start = 1'b0;
    bus.p1_valid = 1'b0;
    bus.p1_move  = 2'b00;
    bus.p2_valid = 1'b0;
    bus.p2_move  = 2'b00;
    @(negedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_hold", 16'(state_o), 16'd0);

    // directed match following the test plan
    start_match();
    play_round(2'b00, 2'b10, 0, 0, 1'b0, 1'b0);   // stone beats scissors
    play_round(2'b01, 2'b01, 0, 3, 1'b0, 1'b1);   // tie, ena held low 5 cycles
    play_round(2'b00, 2'b00, -1, 2, 1'b0, 1'b0);  // only P2 -> forced P2
    play_round(2'b11, 2'b00, 0, 0, 1'b0, 1'b0);   // invalid -> void
    play_round(2'b01, 2'b00, 1, 0, 1'b0, 1'b0);   // paper beats stone, match over

    // randomized rounds and matches
    for (int r = 0; r < 40; r++) begin
      if (m_over) start_match();
      play_round(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 int'($urandom_range(0, 11)) - 1, int'($urandom_range(0, 11)) - 1,
                 1'b1, 1'b0);
    end

    // reset in the middle of a round discards the captured move
    if (m_over) start_match();
    ena = 1'b1;
    bus.p1_valid = 1'b1;
    bus.p1_move  = 2'b00;
    @(posedge clk);
    @(negedge clk);
    bus.p1_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_state", 16'(state_o), 16'd0);
    start_match();
    play_round(2'b10, 2'b01, -1, 0, 1'b0, 1'b0);  // only P2 this time

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rps_match_ctrl.md
Name: rps_match_ctrl

Overview:
- Match sequencer for the stone/paper/scissors judge datapath.
- Collects one move per player per round over valid/ready handshakes, enforces a per-round timeout and judges the round.
- Keeps scores and declares the match winner once a player reaches WINS_TO_MATCH round wins.
- Sits between the player input pins and the result/score display logic.

Parameters:
- WINS_TO_MATCH, 2, round wins needed to take the match; legal range 1..15.
- TIMEOUT_CYCLES, 255, cycles allowed in COLLECT before a forced round outcome; legal range 1..65535.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous, active-low reset
- ena  input  1  global enable; low freezes all state
- start  input  1  begins a new match; honoured only in IDLE or DONE
- p1_valid  input  1  player 1 move offered
- p1_move  input  2  00 stone, 01 paper, 10 scissors, 11 invalid
- p1_ready  output  1  controller will accept a player 1 move this cycle
- p2_valid  input  1  player 2 move offered
- p2_move  input  2  same encoding as p1_move
- p2_ready  output  1  controller will accept a player 2 move this cycle
- round_done  output  1  one-cycle pulse; round_result is new
- round_result  output  2  00 tie, 01 P1 wins, 10 P2 wins, 11 void; held until the next round_done
- p1_score  output  4  P1 round wins in the current match
- p2_score  output  4  P2 round wins in the current match
- match_done  output  1  high while in DONE
- match_winner  output  2  01 P1, 10 P2, 00 while no match is decided
- state_o  output  3  current FSM state, for debug

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. Reset forces state IDLE and drives every output to 0, including scores, round_result, match_winner and the ready outputs.
- ena low: no state change, no capture, timer held; p1_ready and p2_ready forced to 0; all other outputs hold their values.
- FSM encoding (state_o): IDLE=0, COLLECT=1, JUDGE=2, REPORT=3, DONE=4.
- IDLE: start=1 clears both scores, match_winner and the timer, then goes to COLLECT.
- COLLECT:
  - pN_ready = 1 while player N's move is not yet captured.
  - A capture happens on a clock edge with pN_valid & pN_ready.
  - Both players may be captured on the same edge.
  - Once captured, a player's ready stays 0 for the rest of the round.
  - The timer counts every enabled COLLECT cycle.
  - When both moves are captured, go to JUDGE on the next edge.
- Timeout: the timer reaches TIMEOUT_CYCLES with at least one move still missing. On that edge go to JUDGE with a forced result:
  - only P1 captured -> 01;
  - only P2 captured -> 10;
  - neither captured -> 11.
- A capture on the timeout edge itself counts as a capture.
- JUDGE (1 cycle):
  - Compute the result with rps_judge unless it is forced by timeout.
  - Rule: any move equal to 11 -> 11; equal moves -> 00; 00>10, 01>00, 10>01 -> winner.
  - On exit, register round_result, increment the winner's score (no change on 00/11) and go to REPORT.
- REPORT (1 cycle):
  - round_done=1.
  - Next state: DONE if p1_score or p2_score equals WINS_TO_MATCH, with match_winner set accordingly; otherwise COLLECT with the timer and capture flags cleared.
- Latency: the last capture edge E0 enters JUDGE. Result and score are updated at E1, and round_done is high in the cycle after E1.
- DONE: match_done=1; outputs hold. start=1 behaves exactly as start in IDLE.
- Ignored inputs: start is ignored in COLLECT, JUDGE and REPORT. Valid inputs are ignored outside COLLECT.
- Scores cannot overflow: the match ends when a score reaches WINS_TO_MATCH, which is at most 15.
- Reset asserted mid-round: immediate return to IDLE, captured moves discarded.

Optional Feature:
- Macro: RPS_ASCII_OUT_EN.
- Defined: adds output ascii_out[7:0], registered on the same edge as round_result.
  - 00 -> 0x30 ('0'), 01 -> 0x31 ('1'), 10 -> 0x32 ('2'), 11 -> 0x3F ('?').
  - Reset value 0x00.
- Undefined: the port is absent and no extra logic is built.

Decomposition:
- Package rps_pkg:
  - move constants MOVE_STONE=00, MOVE_PAPER=01, MOVE_SCISSORS=10, MOVE_INVALID=11;
  - result constants RES_TIE, RES_P1, RES_P2, RES_VOID;
  - FSM state constants.
- Sub-module rps_judge: purely combinational, with inputs p1_move and p2_move and output result[1:0].

Test Plan:
- Reset then start; P1=00 and P2=10 in the same cycle -> round_done 2 cycles after capture, round_result=01, p1_score=1, p2_score=0.
- P1 offers 01 three cycles before P2 offers 01 -> p1_ready drops after the P1 capture; result 00; scores unchanged.
- TIMEOUT_CYCLES=8; only P2 offers a move -> forced result 10 after 8 COLLECT cycles; p2_score increments.
- Default parameters; P1 wins two rounds -> match_done=1, match_winner=01, state_o=4; start clears scores to 0 and state_o returns to 1.
- P1 move 11 against P2 move 00 -> round_result=11, no score change; with RPS_ASCII_OUT_EN defined, ascii_out=0x3F.
- Hold ena low for 5 cycles mid-COLLECT while valid is high -> no capture and timer frozen. Assert rst_n low mid-round -> all outputs 0 and state IDLE.
